// File: rtl/map_rom_arbiter.sv
// ----------------------------------------------------------------------------
// map_rom_arbiter
//
// Shares the single map ROM (one row of maze walls per address) between the
// VGA map renderer (display) and the player collision checker. Display has
// fixed priority. A starvation guard makes sure collision reads always
// complete: after STARVE_MAX consecutive denied collision cycles, collision
// wins the next contested cycle. Read latency is one cycle, with one read
// per cycle.
//
// Optional feature (compile-time macro ARB_STATS_EN):
//   Adds the output conflict_cnt[15:0]. It counts cycles in which both
//   requesters ask at once and saturates at 16'hFFFF.
//
// Ports
//   clk          in   1      system clock
//   reset        in   1      synchronous, active-low reset
//   disp_req     in   1      display read request (held with addr until gnt)
//   disp_addr    in   ADDRW  display row address
//   disp_gnt     out  1      display request accepted this cycle (comb)
//   disp_rvalid  out  1      disp_rdata valid (cycle after grant)
//   disp_rdata   out  WIDTH  display row data, 0 when not valid
//   col_req      in   1      collision read request (held with addr until gnt)
//   col_addr     in   ADDRW  collision row address
//   col_gnt      out  1      collision request accepted this cycle (comb)
//   col_rvalid   out  1      col_rdata valid (cycle after grant)
//   col_rdata    out  WIDTH  collision row data, 0 when not valid
//   rom_addr     out  ADDRW  ROM address; granted addr, else last granted addr
//   rom_data     in   WIDTH  ROM registered output (one cycle after rom_addr)
//   conflict_cnt out  16     dual-request cycle count (ARB_STATS_EN only)
//   starve_flag  out  1      collision forced priority pending
// ----------------------------------------------------------------------------
module map_rom_arbiter #(
   parameter int WIDTH      = 30,
   parameter int DEPTH      = 21,
   parameter int ADDRW      = 5,
   parameter int STARVE_MAX = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             disp_req,
   input  logic [ADDRW-1:0] disp_addr,
   output logic             disp_gnt,
   output logic             disp_rvalid,
   output logic [WIDTH-1:0] disp_rdata,
   input  logic             col_req,
   input  logic [ADDRW-1:0] col_addr,
   output logic             col_gnt,
   output logic             col_rvalid,
   output logic [WIDTH-1:0] col_rdata,
   output logic [ADDRW-1:0] rom_addr,
   input  logic [WIDTH-1:0] rom_data,
`ifdef ARB_STATS_EN
   output logic [15:0]      conflict_cnt,
`endif
   output logic             starve_flag
);

   // The counter must be able to hold STARVE_MAX itself.
   localparam int CNTW = $clog2(STARVE_MAX + 1);
   localparam logic [CNTW-1:0]  STARVE_LIM = CNTW'(STARVE_MAX);
   localparam logic [ADDRW:0]   DEPTH_L    = (ADDRW + 1)'(DEPTH);

   // Rows at or beyond DEPTH do not exist; they read back as solid wall.
   function automatic logic addr_oor(input logic [ADDRW-1:0] a);
      return ({1'b0, a} >= DEPTH_L);
   endfunction

   logic [CNTW-1:0]  starve_cnt_r;
   logic             starve_hit_s;
   logic             disp_gnt_s;
   logic             col_gnt_s;
   logic [ADDRW-1:0] rom_addr_s;
   logic [ADDRW-1:0] last_addr_r;
   logic             disp_rvalid_r;
   logic             disp_oor_r;
   logic             col_rvalid_r;
   logic             col_oor_r;

   assign starve_hit_s = (starve_cnt_r == STARVE_LIM);

   // Grant selection: display first unless collision has been starved.
   always_comb begin
      disp_gnt_s = 1'b0;
      col_gnt_s  = 1'b0;
      if (!reset) begin
         disp_gnt_s = 1'b0;
         col_gnt_s  = 1'b0;
      end else if (disp_req && col_req) begin
         if (starve_hit_s) begin
            col_gnt_s = 1'b1;
         end else begin
            disp_gnt_s = 1'b1;
         end
      end else if (disp_req) begin
         disp_gnt_s = 1'b1;
      end else if (col_req) begin
         col_gnt_s = 1'b1;
      end else begin
         disp_gnt_s = 1'b0;
         col_gnt_s  = 1'b0;
      end
   end

   // ROM address mux; holds the last granted address when idle.
   always_comb begin
      rom_addr_s = last_addr_r;
      if (!reset) begin
         rom_addr_s = '0;
      end else if (disp_gnt_s) begin
         rom_addr_s = disp_addr;
      end else if (col_gnt_s) begin
         rom_addr_s = col_addr;
      end else begin
         rom_addr_s = last_addr_r;
      end
   end

   // Read-return pipeline, starvation counter and held address.
   always_ff @(posedge clk) begin
      if (!reset) begin
         disp_rvalid_r <= 1'b0;
         disp_oor_r    <= 1'b0;
         col_rvalid_r  <= 1'b0;
         col_oor_r     <= 1'b0;
         starve_cnt_r  <= '0;
         last_addr_r   <= '0;
      end else begin
         disp_rvalid_r <= disp_gnt_s;
         disp_oor_r    <= disp_gnt_s & addr_oor(disp_addr);
         col_rvalid_r  <= col_gnt_s;
         col_oor_r     <= col_gnt_s & addr_oor(col_addr);
         last_addr_r   <= rom_addr_s;
         if (col_gnt_s) begin
            starve_cnt_r <= '0;
         end else if (col_req && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + CNTW'(1);
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end
   end

   // Return data: ROM row, all-ones for out-of-range rows, zero when idle.
   always_comb begin
      disp_rdata = '0;
      col_rdata  = '0;
      if (disp_rvalid_r) begin
         disp_rdata = disp_oor_r ? {WIDTH{1'b1}} : rom_data;
      end else begin
         disp_rdata = '0;
      end
      if (col_rvalid_r) begin
         col_rdata = col_oor_r ? {WIDTH{1'b1}} : rom_data;
      end else begin
         col_rdata = '0;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] conflict_cnt_r;

   // Saturating count of contested cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         conflict_cnt_r <= 16'h0000;
      end else if (disp_req && col_req && (conflict_cnt_r != 16'hFFFF)) begin
         conflict_cnt_r <= conflict_cnt_r + 16'h0001;
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign conflict_cnt = conflict_cnt_r;
`endif

   assign disp_gnt    = disp_gnt_s;
   assign col_gnt     = col_gnt_s;
   assign rom_addr    = rom_addr_s;
   assign disp_rvalid = disp_rvalid_r;
   assign col_rvalid  = col_rvalid_r;
   assign starve_flag = starve_hit_s;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_map_rom_arbiter
//
// Directed vectors drive both requesters cycle by cycle. Each vector carries
// hand-derived grants, starve_flag and rom_addr, checked on the falling edge.
// Every expected grant pushes the expected read data into a per-requester
// queue. An independent monitor pops and compares whenever an rvalid appears.
// A small ROM model holds row r = {6{r[4:0]}}. Rows >= 21 return 0 from the
// model, so the all-ones wall pattern has to come from the arbiter.
// ----------------------------------------------------------------------------
module tb_map_rom_arbiter;

   logic        clk;
   logic        reset;
   logic        disp_req;
   logic [4:0]  disp_addr;
   logic        disp_gnt;
   logic        disp_rvalid;
   logic [29:0] disp_rdata;
   logic        col_req;
   logic [4:0]  col_addr;
   logic        col_gnt;
   logic        col_rvalid;
   logic [29:0] col_rdata;
   logic [4:0]  rom_addr;
   logic [29:0] rom_data;
   logic        starve_flag;
`ifdef ARB_STATS_EN
   logic [15:0] conflict_cnt;
   int          exp_conf;
`endif

   int n_chk;
   int n_fail;

   logic [29:0] disp_q[$];
   logic [29:0] col_q[$];

   typedef struct {
      bit         rst;
      bit         late;
      bit         dr;
      logic [4:0] da;
      bit         cr;
      logic [4:0] ca;
      bit         egd;
      bit         egc;
      bit         ef;
      logic [4:0] erom;
   } vec_t;

   vec_t vq[$];

   map_rom_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .disp_req    (disp_req),
      .disp_addr   (disp_addr),
      .disp_gnt    (disp_gnt),
      .disp_rvalid (disp_rvalid),
      .disp_rdata  (disp_rdata),
      .col_req     (col_req),
      .col_addr    (col_addr),
      .col_gnt     (col_gnt),
      .col_rvalid  (col_rvalid),
      .col_rdata   (col_rdata),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
`ifdef ARB_STATS_EN
      .conflict_cnt(conflict_cnt),
`endif
      .starve_flag (starve_flag)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ROM model: registered output, nonexistent rows read as 0.
   always @(posedge clk) begin
      if (rom_addr < 5'd21) begin
         rom_data <= {6{rom_addr}};
      end else begin
         rom_data <= 30'h0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [29:0] exp_row(input logic [4:0] a);
      return (a < 5'd21) ? {6{a}} : 30'h3FFFFFFF;
   endfunction

   task automatic add(input bit rst, input bit late, input bit dr, input logic [4:0] da,
                      input bit cr, input logic [4:0] ca, input bit egd, input bit egc,
                      input bit ef, input logic [4:0] erom);
      vq.push_back('{rst, late, dr, da, cr, ca, egd, egc, ef, erom});
   endtask

   // Monitor: compares returned data against the scoreboard queues.
   always @(negedge clk) begin
      logic [29:0] e;
      if (disp_rvalid === 1'b1) begin
         if (disp_q.size() == 0) begin
            chk("disp_unexpected_rvalid", 32'(disp_rvalid), 32'd0);
         end else begin
            e = disp_q.pop_front();
            chk("disp_rdata", 32'(disp_rdata), 32'(e));
         end
      end else begin
         chk("disp_rdata_idle", 32'(disp_rdata), 32'd0);
      end
      if (col_rvalid === 1'b1) begin
         if (col_q.size() == 0) begin
            chk("col_unexpected_rvalid", 32'(col_rvalid), 32'd0);
         end else begin
            e = col_q.pop_front();
            chk("col_rdata", 32'(col_rdata), 32'(e));
         end
      end else begin
         chk("col_rdata_idle", 32'(col_rdata), 32'd0);
      end
   end

   // Stimulus: builds the vector table and plays it back one row per cycle.
   initial begin
      vec_t v;
      n_chk     = 0;
      n_fail    = 0;
      reset     = 1'b0;
      disp_req  = 1'b0;
      disp_addr = 5'd0;
      col_req   = 1'b0;
      col_addr  = 5'd0;
`ifdef ARB_STATS_EN
      exp_conf  = 0;
`endif

      // Reset, including requests while reset is low.
      add(1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0);
      add(1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0);
      add(1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 5'd6,  1'b0, 1'b0, 1'b0, 5'd0);
      // Collision alone, then idle holds the address.
      add(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd5,  1'b0, 1'b1, 1'b0, 5'd5);
      add(1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd5);
      // Out-of-range collision row, in-range edge rows, out-of-range display.
      add(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd21, 1'b0, 1'b1, 1'b0, 5'd21);
      add(1'b1, 1'b0, 1'b1, 5'd20, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd20);
      add(1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0);
      add(1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd31);
      // Back-to-back collision grants.
      add(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd1,  1'b0, 1'b1, 1'b0, 5'd1);
      add(1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd2,  1'b0, 1'b1, 1'b0, 5'd2);
      add(1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd2);
      // Both held: display 8 times, forced collision, display again.
      for (int k = 0; k < 8; k++) begin
         add(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd3);
      end
      add(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7);
      add(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd3);
      // Alternating display with collision held: flag never rises.
      for (int k = 0; k < 6; k++) begin
         add(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7);
         add(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd3);
      end
      // Counter is 1 here; 7 more denials reach the limit.
      for (int k = 0; k < 7; k++) begin
         add(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd3);
      end
      // Forced collision grant dropped by reset at the end of its cycle.
      add(1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7);
      add(1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0);
      // Counter cleared by reset, so display wins again.
      add(1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd9);
      add(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9);
      add(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9);

      foreach (vq[i]) begin
         v = vq[i];
         @(posedge clk);
         #1;
         reset     = v.rst;
         disp_req  = v.dr;
         disp_addr = v.da;
         col_req   = v.cr;
         col_addr  = v.ca;
         @(negedge clk);
         chk($sformatf("disp_gnt[%0d]", i), 32'(disp_gnt), 32'(v.egd));
         chk($sformatf("col_gnt[%0d]", i), 32'(col_gnt), 32'(v.egc));
         chk($sformatf("starve_flag[%0d]", i), 32'(starve_flag), 32'(v.ef));
         chk($sformatf("rom_addr[%0d]", i), 32'(rom_addr), 32'(v.erom));
`ifdef ARB_STATS_EN
         chk($sformatf("conflict_cnt[%0d]", i), 32'(conflict_cnt), 32'(exp_conf));
         if (!v.rst || v.late) begin
            exp_conf = 0;
         end else if (v.dr && v.cr) begin
            exp_conf++;
         end
`endif
         if (v.late) begin
            #1;
            reset = 1'b0;
         end else begin
            if (v.egd) disp_q.push_back(exp_row(v.da));
            if (v.egc) col_q.push_back(exp_row(v.ca));
         end
      end

      @(posedge clk);
      #1;
      disp_req = 1'b0;
      col_req  = 1'b0;
      repeat (3) @(negedge clk);
      chk("disp_q_drained", 32'(disp_q.size()), 32'd0);
      chk("col_q_drained", 32'(col_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
